// File: rtl/fwd_hazard_unit.sv
// Forwarding-select precompute (ID -> registered EX selects), load-use and mul/div hazard stall.
// Latency: fwd_sel 1 cycle after ID; stall combinational; md_done MD_LAT cycles after md_start.
// Backpressure: stall holds PC/IF-ID and bubbles EX; optional FWD_STALL_CNT_EN adds stall counters.
module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int MD_LAT  = 4,
  parameter int SELW    = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_FWD*REG_AW-1:0] pipe_rd,
  input  logic [NUM_FWD-1:0]        pipe_wb,
  input  logic                      ex_mem_read,
  input  logic                      md_start,
  input  logic [REG_AW-1:0]         md_rd,
  input  logic                      flush,
  output logic                      stall,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      md_busy,
  output logic                      md_done
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               md_stall_cnt
`endif
);

  localparam int CNTW = $clog2(MD_LAT);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t                  md_state;
  logic [CNTW-1:0]            md_cnt;
  logic [REG_AW-1:0]          md_rd_q;
  logic [NUM_SRC*SELW-1:0]    fwd_pre;
  logic                       lu_stall;
  logic                       md_stall;

  // Select precompute: scan oldest to youngest so the youngest matching producer overwrites.
  always_comb begin
    fwd_pre = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src[i*REG_AW +: REG_AW] != '0)) begin
        for (int k = NUM_FWD; k >= 1; k--) begin
          if (pipe_wb[k-1] && (pipe_rd[(k-1)*REG_AW +: REG_AW] == id_src[i*REG_AW +: REG_AW])) begin
            fwd_pre[i*SELW +: SELW] = SELW'(k);
          end
        end
      end
    end
  end

  // Hazard detection: load in EX feeding a used source, or a used source waiting on the mul/div result.
  always_comb begin
    lu_stall = 1'b0;
    md_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_mem_read && pipe_wb[0] && (pipe_rd[0 +: REG_AW] != '0) &&
          id_src_used[i] && (id_src[i*REG_AW +: REG_AW] == pipe_rd[0 +: REG_AW])) begin
        lu_stall = 1'b1;
      end
      // A latched md_rd of 0 can never match because register 0 sources are excluded.
      if ((md_busy || md_done) && id_src_used[i] &&
          (id_src[i*REG_AW +: REG_AW] != '0) && (id_src[i*REG_AW +: REG_AW] == md_rd_q)) begin
        md_stall = 1'b1;
      end
    end
  end

  assign stall = rst_n & (lu_stall | md_stall);

  // EX select register: a flushed or stalled slot enters EX as a bubble reading the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_sel <= '0;
    end else if (flush || stall) begin
      fwd_sel <= '0;
    end else begin
      fwd_sel <= fwd_pre;
    end
  end

  // Mul/div tracker: counts down the in-flight operation; a start while busy is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
      md_rd_q  <= '0;
      md_busy  <= 1'b0;
      md_done  <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (md_state)
        MD_IDLE: begin
          if (md_start) begin
            md_state <= MD_BUSY;
            md_cnt   <= CNTW'(MD_LAT - 1);
            md_rd_q  <= md_rd;
            md_busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          md_cnt <= md_cnt - 1'b1;
          if (md_cnt == CNTW'(1)) begin
            md_state <= MD_IDLE;
            md_busy  <= 1'b0;
            md_done  <= 1'b1;
          end
        end
        default: begin
          md_state <= MD_IDLE;
          md_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FWD_STALL_CNT_EN
  // Saturating counters of all stall cycles and of mul/div-caused stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (md_stall && (md_stall_cnt != 32'hFFFF_FFFF)) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then randomized traffic against a behavioural model.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
// Mul/div starts are only issued when the model says the unit is not busy.
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int MD_LAT  = 4;
  localparam int SELW    = $clog2(NUM_FWD + 1);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_FWD*REG_AW-1:0] pipe_rd;
  logic [NUM_FWD-1:0]        pipe_wb;
  logic                      ex_mem_read;
  logic                      md_start;
  logic [REG_AW-1:0]         md_rd;
  logic                      flush;
  logic                      stall;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      md_busy;
  logic                      md_done;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               md_stall_cnt;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .MD_LAT(MD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_used(id_src_used),
    .pipe_rd(pipe_rd), .pipe_wb(pipe_wb), .ex_mem_read(ex_mem_read),
    .md_start(md_start), .md_rd(md_rd), .flush(flush), .stall(stall),
    .fwd_sel(fwd_sel), .md_busy(md_busy), .md_done(md_done)
`ifdef FWD_STALL_CNT_EN
    , .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // stimulus for the next cycle
  int s_src[NUM_SRC];
  int s_used[NUM_SRC];
  int s_prd[NUM_FWD];
  int s_pwb[NUM_FWD];
  int s_lw, s_mds, s_mdrd, s_flush, s_rst;

  // model state: md_t = cycles since the mul/div was accepted (0 = none in flight)
  int md_t;
  int md_rd_m;
  int fsel_m[NUM_SRC];
  longint sc_m, msc_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr_in();
    for (int i = 0; i < NUM_SRC; i++) begin s_src[i] = 0; s_used[i] = 1; end
    for (int k = 0; k < NUM_FWD; k++) begin s_prd[k] = 0; s_pwb[k] = 0; end
    s_lw = 0; s_mds = 0; s_mdrd = 0; s_flush = 0; s_rst = 1;
  endtask

  function automatic int model_sel(input int i);
    for (int k = 1; k <= NUM_FWD; k++)
      if (s_pwb[k-1] != 0 && s_prd[k-1] == s_src[i]) return k;
    return 0;
  endfunction

  task automatic step();
    bit lu, mh, st;
    @(negedge clk);
    rst_n = s_rst[0];
    for (int i = 0; i < NUM_SRC; i++) begin
      id_src[i*REG_AW +: REG_AW] = REG_AW'(s_src[i]);
      id_src_used[i] = s_used[i][0];
    end
    for (int k = 0; k < NUM_FWD; k++) begin
      pipe_rd[k*REG_AW +: REG_AW] = REG_AW'(s_prd[k]);
      pipe_wb[k] = s_pwb[k][0];
    end
    ex_mem_read = s_lw[0];
    md_start    = s_mds[0];
    md_rd       = REG_AW'(s_mdrd);
    flush       = s_flush[0];
    #1;
    lu = 0;
    mh = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (s_lw != 0 && s_pwb[0] != 0 && s_prd[0] != 0 && s_used[i] != 0 && s_src[i] == s_prd[0]) lu = 1;
      if (md_t >= 1 && s_used[i] != 0 && s_src[i] != 0 && s_src[i] == md_rd_m) mh = 1;
    end
    st = (s_rst != 0) && (lu || mh);
    chk("stall", 32'(stall), 32'(st));
    for (int i = 0; i < NUM_SRC; i++) chk("fwd_sel", 32'(fwd_sel[i*SELW +: SELW]), 32'(fsel_m[i]));
    chk("md_busy", 32'(md_busy), 32'(md_t >= 1 && md_t < MD_LAT));
    chk("md_done", 32'(md_done), 32'(md_t == MD_LAT));
`ifdef FWD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(sc_m));
    chk("md_stall_cnt", md_stall_cnt, 32'(msc_m));
`endif
    // advance model to the state after the coming rising edge
    if (s_rst == 0) begin
      md_t = 0; md_rd_m = 0; sc_m = 0; msc_m = 0;
      for (int i = 0; i < NUM_SRC; i++) fsel_m[i] = 0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++)
        fsel_m[i] = (s_flush != 0 || st || s_used[i] == 0 || s_src[i] == 0) ? 0 : model_sel(i);
      if (st && sc_m < 64'hFFFF_FFFF) sc_m++;
      if (mh && msc_m < 64'hFFFF_FFFF) msc_m++;
      if (md_t >= 1 && md_t < MD_LAT) md_t++;
      else if (s_mds != 0) begin md_t = 1; md_rd_m = s_mdrd; end
      else md_t = 0;
    end
  endtask

  initial begin
    clr_in();
    s_rst = 0;
    rst_n = 1'b0; id_src = '0; id_src_used = '0; pipe_rd = '0; pipe_wb = '0;
    ex_mem_read = 1'b0; md_start = 1'b0; md_rd = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    md_t = 0; md_rd_m = 0; sc_m = 0; msc_m = 0;
    for (int i = 0; i < NUM_SRC; i++) fsel_m[i] = 0;

    // reset with a load-use hazard on the inputs: stall must stay low
    s_lw = 1; s_prd[0] = 8; s_pwb[0] = 1; s_src[1] = 8;
    step();
    chk("rst_stall", 32'(stall), 32'd0);

    // double hazard: youngest producer wins, then the older one when EX does not write
    clr_in(); s_src[0] = 3; s_src[1] = 3; s_prd[0] = 3; s_prd[1] = 3; s_pwb[0] = 1; s_pwb[1] = 1;
    step(); clr_in(); step();
    chk("dbl_young", 32'(fwd_sel), 32'b0101);
    clr_in(); s_src[0] = 3; s_src[1] = 3; s_prd[0] = 3; s_prd[1] = 3; s_pwb[1] = 1;
    step(); clr_in(); step();
    chk("dbl_old", 32'(fwd_sel), 32'b1010);

    // register 0 never forwards nor stalls
    clr_in(); s_src[0] = 0; s_src[1] = 5; s_prd[1] = 7; s_pwb[0] = 1; s_lw = 1;
    step();
    chk("r0_stall", 32'(stall), 32'd0);
    clr_in(); step();
    chk("r0_sel", 32'(fwd_sel), 32'd0);

    // load-use: one stall cycle, then forwarded from stage 2
    clr_in(); s_src[0] = 2; s_src[1] = 8; s_lw = 1; s_prd[0] = 8; s_pwb[0] = 1;
    step();
    chk("lu_stall", 32'(stall), 32'd1);
    clr_in(); s_src[0] = 2; s_src[1] = 8; s_prd[0] = 1; s_prd[1] = 8; s_pwb[1] = 1;
    step();
    chk("lu_release", 32'(stall), 32'd0);
    chk("lu_bubble", 32'(fwd_sel), 32'd0);
    clr_in(); step();
    chk("lu_fwd2", 32'(fwd_sel), 32'b1000);

    // unused source does not trigger load-use
    clr_in(); s_src[1] = 8; s_used[1] = 0; s_lw = 1; s_prd[0] = 8; s_pwb[0] = 1;
    step();
    chk("unused_stall", 32'(stall), 32'd0);

    // mul/div timeline with a dependent ID instruction
    clr_in(); s_mds = 1; s_mdrd = 9;
    step();
    for (int c = 1; c <= 5; c++) begin
      clr_in(); s_src[0] = 9; s_used[1] = 0;
      step();
      chk("md_tl_busy", 32'(md_busy), 32'(c <= 3));
      chk("md_tl_done", 32'(md_done), 32'(c == 4));
      chk("md_tl_stall", 32'(stall), 32'(c <= 4));
    end

    // reset in the middle of a mul/div
    clr_in(); s_mds = 1; s_mdrd = 9;
    step();
    clr_in(); s_src[0] = 9; step();
    clr_in(); s_src[0] = 9; s_rst = 0; step();
    chk("mid_rst_stall", 32'(stall), 32'd0);
    for (int c = 3; c <= 5; c++) begin
      clr_in(); s_src[0] = 9; step();
      chk("mid_rst_busy", 32'(md_busy), 32'd0);
      chk("mid_rst_done", 32'(md_done), 32'd0);
      chk("mid_rst_stall2", 32'(stall), 32'd0);
    end
`ifdef FWD_STALL_CNT_EN
    chk("mid_rst_cnt", stall_cnt, 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        s_src[i] = $urandom_range(0, 3);
        s_used[i] = ($urandom_range(0, 3) != 0);
      end
      for (int k = 0; k < NUM_FWD; k++) begin
        s_prd[k] = $urandom_range(0, 3);
        s_pwb[k] = $urandom_range(0, 1);
      end
      s_lw    = ($urandom_range(0, 3) == 0);
      s_mds   = (!(md_t >= 1 && md_t < MD_LAT)) && ($urandom_range(0, 5) == 0);
      s_mdrd  = $urandom_range(0, 3);
      s_flush = ($urandom_range(0, 7) == 0);
      s_rst   = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
